p09_game_ctrl: RTL and testbench

- Frame-synchronous game sequencer for the breakout project.
- Owns the game state (attract, serve, play, life lost, wall cleared, game over) and the life counter.
- Drives the control inputs of the layer mux and its layer generators: ball/lives visibility, border colour, ball motion enable, and reinitialisation pulses for the ball/paddle and the block wall.
- Sits between the button/collision logic and the video mux; counts time in frames, not pixels.

---
 rtl/p09_pkg.sv | 26 ++
 rtl/p09_frame_timer.sv | 29 ++
 rtl/p09_game_ctrl.sv | 157 +++++++++++++++
 tb/tb_p09_game_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/p09_pkg.sv
// Shared definitions for the breakout game sequencer and the layer mux wrapper.
package p09_pkg;

  typedef enum logic [2:0] {
    ST_ATTRACT = 3'd0,
    ST_SERVE   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_LOST    = 3'd3,
    ST_WON     = 3'd4,
    ST_OVER    = 3'd5
  } state_e;

  localparam logic [5:0] BORDER_NORMAL = 6'b010101;
  localparam logic [5:0] BORDER_HIT_A  = 6'b110000;
  localparam logic [5:0] BORDER_HIT_B  = 6'b111111;
  localparam logic [5:0] BORDER_WIN    = 6'b001100;

  function automatic logic [1:0] lives_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  function automatic logic [1:0] lives_dec(input logic [1:0] v);
    return (v == 2'd0) ? v : v - 2'd1;
  endfunction

endpackage

// File: rtl/p09_frame_timer.sv
// Frame-tick counter for timed game states; expire pulses on the tick that
// brings the count up to the limit.
module p09_frame_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       tick,
  input  logic [7:0] limit,
  output logic [7:0] count,
  output logic       expire
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)     count_d = 8'd0;
    else if (tick) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= 8'd0;
    else     count_q <= count_d;
  end

  assign count  = count_q;
  assign expire = tick && ((count_q + 8'd1) == limit);

endmodule

// File: rtl/p09_game_ctrl.sv
// Breakout game sequencer: game state, life counter and layer-control outputs.
//   state   | meaning
//   ATTRACT | idle demo, waiting for serve
//   SERVE   | ball shown and parked, waiting for serve
//   PLAY    | ball in motion
//   LOST    | ball missed, border flashes for LOST_FRAMES
//   WON     | wall cleared, win border for WON_FRAMES
//   OVER    | no lives left, lives blink for OVER_FRAMES
module p09_game_ctrl
  import p09_pkg::*;
#(
  parameter int LIVES_INIT  = 3,
  parameter int LOST_FRAMES = 60,
  parameter int WON_FRAMES  = 90,
  parameter int OVER_FRAMES = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_serve,
  input  logic       ball_lost,
  input  logic       blocks_clear,
  output logic [2:0] state,
  output logic [1:0] lives,
  output logic       ball_run,
  output logic       ball_show,
  output logic       lives_show,
  output logic [5:0] border_color,
  output logic       round_reset,
  output logic       blocks_reset
);

  state_e     state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic       btn_q, mask_q;
  logic       run_q, show_q, lshow_q, round_q, blocks_q;
  logic [5:0] border_q;
  logic       round_go, blocks_go;
  logic       serve_edge, timer_clear, expire;
  logic [7:0] count, limit, cnt_nx;

  // First cycle after reset is masked so a button held through reset cannot serve.
  assign serve_edge  = btn_serve & ~btn_q & ~mask_q;
  assign timer_clear = (state_d != state_q);
  assign cnt_nx      = timer_clear ? 8'd0 : count + {7'd0, frame_tick};

  always_comb begin
    case (state_q)
      ST_LOST: limit = 8'(LOST_FRAMES);
      ST_WON:  limit = 8'(WON_FRAMES);
      ST_OVER: limit = 8'(OVER_FRAMES);
      default: limit = 8'hFF;
    endcase
  end

  p09_frame_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .tick   (frame_tick),
    .limit  (limit),
    .count  (count),
    .expire (expire)
  );

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    round_go  = 1'b0;
    blocks_go = 1'b0;
    case (state_q)
      ST_ATTRACT: if (serve_edge) begin
        state_d   = ST_SERVE;
        lives_d   = 2'(LIVES_INIT);
        round_go  = 1'b1;
        blocks_go = 1'b1;
      end
      ST_SERVE: if (serve_edge) state_d = ST_PLAY;
      ST_PLAY: begin
        if (blocks_clear) state_d = ST_WON;
        else if (ball_lost) begin
          state_d = ST_LOST;
          lives_d = lives_dec(lives_q);
        end
      end
      ST_LOST: if (expire) begin
        if (lives_q == 2'd0) state_d = ST_OVER;
        else begin
          state_d  = ST_SERVE;
          round_go = 1'b1;
        end
      end
      ST_WON: if (expire) begin
        state_d   = ST_SERVE;
        lives_d   = lives_inc(lives_q);
        round_go  = 1'b1;
        blocks_go = 1'b1;
      end
      ST_OVER: if (expire) state_d = ST_ATTRACT;
      default: state_d = ST_ATTRACT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_ATTRACT;
      lives_q  <= 2'(LIVES_INIT);
      btn_q    <= 1'b0;
      mask_q   <= 1'b1;
      run_q    <= 1'b0;
      show_q   <= 1'b0;
      lshow_q  <= 1'b1;
      border_q <= BORDER_NORMAL;
      round_q  <= 1'b0;
      blocks_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      btn_q    <= btn_serve;
      mask_q   <= 1'b0;
      round_q  <= round_go;
      blocks_q <= blocks_go;
      // Outputs are decoded from the state and timer value being entered.
      case (state_d)
        ST_SERVE: begin
          run_q <= 1'b0; show_q <= 1'b1; lshow_q <= 1'b1; border_q <= BORDER_NORMAL;
        end
        ST_PLAY: begin
          run_q <= 1'b1; show_q <= 1'b1; lshow_q <= 1'b1; border_q <= BORDER_NORMAL;
        end
        ST_LOST: begin
          run_q <= 1'b0; show_q <= 1'b0; lshow_q <= 1'b1;
          border_q <= cnt_nx[2] ? BORDER_HIT_B : BORDER_HIT_A;
        end
        ST_WON: begin
          run_q <= 1'b0; show_q <= 1'b1; lshow_q <= 1'b1; border_q <= BORDER_WIN;
        end
        ST_OVER: begin
          run_q <= 1'b0; show_q <= 1'b0; lshow_q <= ~cnt_nx[3]; border_q <= BORDER_NORMAL;
        end
        default: begin
          run_q <= 1'b0; show_q <= 1'b0; lshow_q <= 1'b1; border_q <= BORDER_NORMAL;
        end
      endcase
    end
  end

  assign state        = state_q;
  assign lives        = lives_q;
  assign ball_run     = run_q;
  assign ball_show    = show_q;
  assign lives_show   = lshow_q;
  assign border_color = border_q;
  assign round_reset  = round_q;
  assign blocks_reset = blocks_q;

endmodule

// File: tb/tb_p09_game_ctrl.sv
// Directed bench for the breakout game sequencer.
module tb_p09_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_serve = 1'b0;
  logic       ball_lost = 1'b0;
  logic       blocks_clear = 1'b0;
  logic [2:0] state;
  logic [1:0] lives;
  logic       ball_run, ball_show, lives_show, round_reset, blocks_reset;
  logic [5:0] border_color;

  int tests = 0;
  int fails = 0;

  localparam logic [5:0] B_NORM = 6'h15;
  localparam logic [5:0] B_HA   = 6'h30;
  localparam logic [5:0] B_HB   = 6'h3F;
  localparam logic [5:0] B_WIN  = 6'h0C;

  p09_game_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .btn_serve    (btn_serve),
    .ball_lost    (ball_lost),
    .blocks_clear (blocks_clear),
    .state        (state),
    .lives        (lives),
    .ball_run     (ball_run),
    .ball_show    (ball_show),
    .lives_show   (lives_show),
    .border_color (border_color),
    .round_reset  (round_reset),
    .blocks_reset (blocks_reset)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press();
    btn_serve = 1'b0;
    step();
    btn_serve = 1'b1;
    step();
    btn_serve = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  initial begin
    // Reset values
    step(2);
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_lives", 8'(lives), 8'd3);
    chk("rst_run", 8'(ball_run), 8'd0);
    chk("rst_show", 8'(ball_show), 8'd0);
    chk("rst_lshow", 8'(lives_show), 8'd1);
    chk("rst_border", 8'(border_color), 8'(B_NORM));
    chk("rst_pulses", 8'({round_reset, blocks_reset}), 8'd0);
    rst = 1'b0;
    step();

    // Serve from ATTRACT with one-cycle pulses
    press();
    chk("serve_state", 8'(state), 8'd1);
    chk("serve_pulses", 8'({round_reset, blocks_reset}), 8'd3);
    chk("serve_show", 8'(ball_show), 8'd1);
    step();
    chk("serve_pulses_off", 8'({round_reset, blocks_reset}), 8'd0);
    ball_lost = 1'b1; blocks_clear = 1'b1;
    step();
    ball_lost = 1'b0; blocks_clear = 1'b0;
    chk("serve_ignore_lost", 8'({state, lives}), 8'({3'd1, 2'd3}));
    press();
    chk("play_state", 8'(state), 8'd2);
    chk("play_run", 8'(ball_run), 8'd1);

    // Ticks in PLAY must not leak into LOST; tick coincident with the loss is dropped
    ticks(5);
    ball_lost = 1'b1; frame_tick = 1'b1;
    step();
    ball_lost = 1'b0; frame_tick = 1'b0;
    chk("lost_state", 8'(state), 8'd3);
    chk("lost_lives", 8'(lives), 8'd2);
    chk("lost_show", 8'({ball_show, ball_run}), 8'd0);
    chk("lost_border0", 8'(border_color), 8'(B_HA));
    ticks(3);
    chk("lost_border3", 8'(border_color), 8'(B_HA));
    ticks(1);
    chk("lost_border4", 8'(border_color), 8'(B_HB));
    ticks(4);
    chk("lost_border8", 8'(border_color), 8'(B_HA));
    ticks(51);
    chk("lost_59", 8'(state), 8'd3);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("lost_exp_state", 8'(state), 8'd1);
    chk("lost_exp_pulses", 8'({round_reset, blocks_reset}), 8'd2);
    step();
    chk("lost_exp_off", 8'(round_reset), 8'd0);

    // Down to zero lives, then OVER
    press();
    ball_lost = 1'b1; step(); ball_lost = 1'b0;
    chk("lost2_lives", 8'(lives), 8'd1);
    ticks(60);
    chk("lost2_serve", 8'(state), 8'd1);
    press();
    ball_lost = 1'b1; step(); ball_lost = 1'b0;
    chk("lost3_lives", 8'(lives), 8'd0);
    ticks(59);
    chk("lost3_59", 8'(state), 8'd3);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("over_state", 8'(state), 8'd5);
    chk("over_no_pulse", 8'({round_reset, blocks_reset}), 8'd0);
    chk("over_lshow0", 8'(lives_show), 8'd1);
    press();
    chk("over_ignore_serve", 8'(state), 8'd5);
    ticks(7);
    chk("over_lshow7", 8'(lives_show), 8'd1);
    ticks(1);
    chk("over_lshow8", 8'(lives_show), 8'd0);
    ticks(8);
    chk("over_lshow16", 8'(lives_show), 8'd1);
    ticks(163);
    chk("over_179", 8'(state), 8'd5);
    ticks(1);
    chk("over_exp", 8'(state), 8'd0);
    chk("attract_lshow", 8'(lives_show), 8'd1);

    // Simultaneous clear and loss -> WON, lives kept, saturate at 3
    press();
    chk("restart_lives", 8'(lives), 8'd3);
    press();
    blocks_clear = 1'b1; ball_lost = 1'b1; step();
    blocks_clear = 1'b0; ball_lost = 1'b0;
    chk("won_state", 8'(state), 8'd4);
    chk("won_lives", 8'(lives), 8'd3);
    chk("won_border", 8'(border_color), 8'(B_WIN));
    chk("won_run", 8'(ball_run), 8'd0);
    ticks(89);
    chk("won_89", 8'(state), 8'd4);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("won_exp_state", 8'(state), 8'd1);
    chk("won_exp_pulses", 8'({round_reset, blocks_reset}), 8'd3);
    chk("won_exp_lives_sat", 8'(lives), 8'd3);
    step();
    chk("won_exp_off", 8'({round_reset, blocks_reset}), 8'd0);

    // WON with lives=2 increments to 3
    press();
    ball_lost = 1'b1; step(); ball_lost = 1'b0;
    ticks(60);
    press();
    blocks_clear = 1'b1; step(); blocks_clear = 1'b0;
    chk("won2_lives", 8'({state, lives}), 8'({3'd4, 2'd2}));
    ticks(90);
    chk("won2_exp", 8'({state, lives}), 8'({3'd1, 2'd3}));

    // Reset in PLAY
    press();
    ball_lost = 1'b1; step(); ball_lost = 1'b0;
    ticks(60);
    press();
    chk("pre_rst_play", 8'({state, lives}), 8'({3'd2, 2'd2}));
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_play", 8'({state, lives}), 8'({3'd0, 2'd3}));
    chk("rst_play_out", 8'({ball_run, ball_show, round_reset, blocks_reset}), 8'd0);
    step();

    // Reset in the WON expiry cycle
    press();
    press();
    blocks_clear = 1'b1; step(); blocks_clear = 1'b0;
    ticks(89);
    frame_tick = 1'b1; rst = 1'b1; step();
    frame_tick = 1'b0; rst = 1'b0;
    chk("rst_won_exp", 8'({state, lives}), 8'({3'd0, 2'd3}));
    chk("rst_won_pulses", 8'({round_reset, blocks_reset}), 8'd0);
    step();
    chk("rst_won_after", 8'({round_reset, blocks_reset, state}), 8'd0);

    // Button held through reset release
    btn_serve = 1'b1; rst = 1'b1; step(); rst = 1'b0;
    step(3);
    chk("held_rst", 8'(state), 8'd0);
    btn_serve = 1'b0; step();
    btn_serve = 1'b1; step();
    chk("held_serve", 8'(state), 8'd1);
    step(5);
    chk("held_no_repeat", 8'(state), 8'd1);
    btn_serve = 1'b0; step();
    btn_serve = 1'b1; step();
    btn_serve = 1'b0;
    chk("held_play", 8'(state), 8'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
